// File: rtl/apb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// apb_arbiter_pkg
//   Shared definitions for the two-requester APB arbiter.
//   - apb_arb_state_e : arbiter FSM states
//   - APB_ARB_DATA_W  : default address/data width
//   - APB_ARB_MAX_LOCK: default limit on consecutive grants to a locked owner
// ---------------------------------------------------------------------------
package apb_arbiter_pkg;

    localparam int APB_ARB_DATA_W   = 32;
    localparam int APB_ARB_MAX_LOCK = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        SETUP_W  = 3'd2,
        ACCESS_W = 3'd3,
        DONE     = 3'd4
    } apb_arb_state_e;

endpackage

// File: rtl/apb_arb_rr.sv
// ---------------------------------------------------------------------------
// apb_arb_rr
//   Two-input round-robin pick. A lone requester wins outright. On a tie the
//   requester that was not granted last wins, unless lock_keep asks for the
//   previous owner to be granted again.
//
// Ports
//   req0, req1 : request lines
//   last_gnt   : requester granted by the previous completed transfer
//   lock_keep  : tie goes to last_gnt instead of the other requester
//   valid      : at least one request present
//   gnt        : index of the winning requester
// ---------------------------------------------------------------------------
module apb_arb_rr
    import apb_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    input  logic lock_keep,
    output logic valid,
    output logic gnt
);

    always_comb begin
        valid = req0 | req1;
        gnt   = 1'b0;
        if (req0 && req1) begin
            gnt = lock_keep ? last_gnt : ~last_gnt;
        end else if (req1) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// ---------------------------------------------------------------------------
// apb_arbiter
//   Shares one APB master between two requesters. A granted requester gets a
//   one-cycle transfer trigger, the arbiter then waits out the master's setup
//   phase and the slave's access phase, captures the read data and returns a
//   one-cycle done pulse to the owner.
//
//   Optional feature macro: APB_ARB_LOCK_EN
//     defined   : an owner holding lock keeps winning ties, up to MAX_LOCK
//                 consecutive grants
//     undefined : lock0/lock1 are ignored, pure round-robin
//
// Parameters
//   DATA_W   : address/data width
//   MAX_LOCK : max consecutive grants to a locked requester
//
// Ports
//   PCLK, PRESET           : clock, asynchronous active-low reset
//   req0/1, addr0/1,
//   wdata0/1, write0/1,
//   lock0/1                : requester side inputs
//   done0/1                : one-cycle completion pulse per requester
//   rdata_q                : read data captured at the end of the access
//   transfer, addr, wdata,
//   write                  : command to the APB master
//   ready, rdata           : response from the APB master
//   busy                   : arbiter not idle
//   owner                  : current / last granted requester
// ---------------------------------------------------------------------------
module apb_arbiter
    import apb_arbiter_pkg::*;
#(
    parameter int DATA_W   = APB_ARB_DATA_W,
    parameter int MAX_LOCK = APB_ARB_MAX_LOCK
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              write0,
    input  logic              write1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata_q,
    output logic              transfer,
    output logic [DATA_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              write,
    input  logic              ready,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              owner
);

    apb_arb_state_e state;
    logic           last_gnt;
    logic           lock_keep;
    logic           pick_valid;
    logic           pick_gnt;

`ifdef APB_ARB_LOCK_EN
    // Counter only needs to reach MAX_LOCK-1.
    localparam int LOCK_CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;

    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic                  owner_lock;

    assign owner_lock = owner ? lock1 : lock0;
    // A nonzero count means the last DONE granted the owner another turn.
    assign lock_keep  = (lock_cnt != '0);
`else
    logic unused_lock;

    assign unused_lock = lock0 ^ lock1 ^ (MAX_LOCK == 0);
    assign lock_keep   = 1'b0;
`endif

    apb_arb_rr u_rr (
        .req0      (req0),
        .req1      (req1),
        .last_gnt  (last_gnt),
        .lock_keep (lock_keep),
        .valid     (pick_valid),
        .gnt       (pick_gnt)
    );

    // Command to the APB master follows the owner's inputs directly.
    assign addr  = owner ? addr1  : addr0;
    assign wdata = owner ? wdata1 : wdata0;
    assign write = owner ? write1 : write0;

    // Arbiter FSM. transfer, done and busy are registered so that they change
    // on the same edge as the state they belong to. ready is only looked at in
    // ACCESS_W; during ISSUE/SETUP_W it does not refer to this transfer yet.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            transfer <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            busy     <= 1'b0;
            rdata_q  <= '0;
`ifdef APB_ARB_LOCK_EN
            lock_cnt <= '0;
`endif
        end else begin
            transfer <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner    <= pick_gnt;
                        transfer <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= SETUP_W;
                end
                SETUP_W: begin
                    state <= ACCESS_W;
                end
                ACCESS_W: begin
                    if (ready) begin
                        rdata_q <= rdata;
                        done0   <= ~owner;
                        done1   <= owner;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    last_gnt <= owner;
                    busy     <= 1'b0;
                    state    <= IDLE;
`ifdef APB_ARB_LOCK_EN
                    if (owner_lock && (int'(lock_cnt) < MAX_LOCK - 1)) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end else begin
                        lock_cnt <= '0;
                    end
`endif
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_arbiter
//   Self-checking bench for apb_arbiter. A transaction-level model tracks who
//   should be granted (round-robin plus optional lock streak) and the expected
//   completion latency; each test task drives stimulus and compares inline.
// ---------------------------------------------------------------------------
module tb_apb_arbiter;

    localparam int DW = 32;
    localparam int ML = 4;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          req0, req1, write0, write1, lock0, lock1, ready;
    logic [DW-1:0] addr0, addr1, wdata0, wdata1, rdata;
    logic          done0, done1, transfer, write, busy, owner;
    logic [DW-1:0] rdata_q, addr, wdata;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] last_rd;

    // Model state: last granted requester and length of the current lock streak.
    logic          m_last;
    int            m_streak;

    apb_arbiter #(.DATA_W(DW), .MAX_LOCK(ML)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .write0(write0), .write1(write1),
        .lock0(lock0), .lock1(lock1),
        .done0(done0), .done1(done1),
        .rdata_q(rdata_q), .transfer(transfer),
        .addr(addr), .wdata(wdata), .write(write),
        .ready(ready), .rdata(rdata),
        .busy(busy), .owner(owner)
    );

    always #5 PCLK = ~PCLK;

    function automatic void model_reset();
        m_last   = 1'b1;
        m_streak = 0;
    endfunction

    function automatic logic model_winner(input logic r0, input logic r1);
        if (r0 && !r1) return 1'b0;
        if (r1 && !r0) return 1'b1;
        return (m_streak > 0) ? m_last : ~m_last;
    endfunction

    function automatic void model_finish(input logic own, input logic lk);
        m_last = own;
`ifdef APB_ARB_LOCK_EN
        if (lk && m_streak < ML - 1) m_streak = m_streak + 1;
        else m_streak = 0;
`else
        if (lk) m_streak = 0;
        m_streak = 0;
`endif
    endfunction

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic zero_inputs();
        req0 = 0; req1 = 0; write0 = 0; write1 = 0; lock0 = 0; lock1 = 0;
        ready = 0; rdata = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        PRESET = 1'b0;
        zero_inputs();
        repeat (2) @(posedge PCLK);
        #3 PRESET = 1'b1;
        model_reset();
        step();
    endtask

    // Acts as the APB master/slave for one transaction and reports what it saw.
    // Cycle numbers are relative to the call (call cycle = 0). drop_mode after
    // done: 0 keep reqs, 1 drop owner's req, 2 drop both.
    task automatic serve_one(input int waits, input bit spurious, input logic [DW-1:0] rd,
                             input int drop_mode, output bit timed_out, output int xfer_cyc,
                             output int done_cyc, output logic own, output logic [DW-1:0] o_addr,
                             output logic [DW-1:0] o_wdata, output logic o_write,
                             output bit bad_done, output int xfer_pulses);
        timed_out = 1'b0; xfer_cyc = -1; done_cyc = -1; own = 1'bx;
        o_addr = 'x; o_wdata = 'x; o_write = 1'bx; bad_done = 1'b0; xfer_pulses = 0;
        ready = 1'b0; rdata = ~rd;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            int rel;
            step();
            if (transfer) begin
                xfer_pulses++;
                if (xfer_cyc < 0) begin
                    xfer_cyc = c; own = owner; o_addr = addr; o_wdata = wdata; o_write = write;
                end
            end
            if (done0 || done1) begin
                done_cyc = c;
                if ((done0 && done1) || (done1 !== own)) bad_done = 1'b1;
            end
            if (xfer_cyc >= 0 && done_cyc < 0) begin
                rel = c - xfer_cyc;
                if (rel < 2) begin ready = spurious; rdata = ~rd; end
                else if (rel < 2 + waits) begin ready = 1'b0; rdata = ~rd; end
                else begin ready = 1'b1; rdata = rd; end
            end else begin
                ready = 1'b0;
            end
            if (done_cyc >= 0) begin
                if (drop_mode == 2) begin req0 = 0; req1 = 0; end
                else if (drop_mode == 1) begin
                    if (own) req1 = 0; else req0 = 0;
                end
            end
        end
        ready = 1'b0;
        if (done_cyc < 0) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        zero_inputs();
        PRESET = 1'b1;
        #2 PRESET = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        total++; if (transfer !== 1'b0) begin bad++; $display("[TB] FAIL rst_transfer: got %b expected 0", transfer); end
        total++; if ({done0, done1} !== 2'b00) begin bad++; $display("[TB] FAIL rst_done: got %b expected 00", {done0, done1}); end
        total++; if (rdata_q !== '0) begin bad++; $display("[TB] FAIL rst_rdata_q: got %h expected 0", rdata_q); end
        total++; if (owner !== 1'b0) begin bad++; $display("[TB] FAIL rst_owner: got %b expected 0", owner); end
        repeat (2) @(posedge PCLK);
        #3 PRESET = 1'b1;
        model_reset();
        step(); step();
        total++; if ({busy, transfer} !== 2'b00) begin bad++; $display("[TB] FAIL rst_idle: got %b expected 00", {busy, transfer}); end
    endtask

    task automatic test_single_read();
        bit to, bd; int xc, dc, nx; logic own, ow, exp_own; logic [DW-1:0] oa, od;
        req0 = 1; req1 = 0; addr0 = 32'h1000_1004; wdata0 = $urandom; write0 = 0;
        addr1 = $urandom; write1 = 1;
        exp_own = model_winner(req0, req1);
        serve_one(0, 0, 32'hDEAD_BEEF, 2, to, xc, dc, own, oa, od, ow, bd, nx);
        model_finish(exp_own, lock0);
        total++; if (to) begin bad++; $display("[TB] FAIL single_timeout: got no done expected done"); end
        total++; if (xc != 1) begin bad++; $display("[TB] FAIL single_xfer_cycle: got %0d expected 1", xc); end
        total++; if (dc != 4) begin bad++; $display("[TB] FAIL single_done_cycle: got %0d expected 4", dc); end
        total++; if (own !== exp_own) begin bad++; $display("[TB] FAIL single_owner: got %b expected %b", own, exp_own); end
        total++; if (oa !== 32'h1000_1004) begin bad++; $display("[TB] FAIL single_addr: got %h expected 10001004", oa); end
        total++; if (ow !== 1'b0) begin bad++; $display("[TB] FAIL single_write: got %b expected 0", ow); end
        total++; if (rdata_q !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL single_rdata_q: got %h expected deadbeef", rdata_q); end
        total++; if (bd) begin bad++; $display("[TB] FAIL single_done_owner: got wrong done line expected done0 only"); end
        step();
        total++; if ({done0, done1, busy} !== 3'b000) begin bad++; $display("[TB] FAIL single_after: got %b expected 000", {done0, done1, busy}); end
        last_rd = 32'hDEAD_BEEF;
    endtask

    task automatic test_simultaneous();
        bit to, bd; int xc, dc, nx; logic own, ow, exp_own; logic [DW-1:0] oa, od;
        do_reset();
        req0 = 1; req1 = 1; addr0 = $urandom; addr1 = $urandom; write0 = 0; write1 = 0;
        exp_own = model_winner(req0, req1);
        serve_one(0, 0, 32'h1111_2222, 1, to, xc, dc, own, oa, od, ow, bd, nx);
        model_finish(exp_own, 1'b0);
        total++; if (own !== 1'b0 || own !== exp_own) begin bad++; $display("[TB] FAIL sim_first_owner: got %b expected 0", own); end
        total++; if (to || bd) begin bad++; $display("[TB] FAIL sim_first_done: got timeout=%b bad=%b expected 0 0", to, bd); end
        exp_own = model_winner(req0, req1);
        serve_one(0, 0, 32'h3333_4444, 2, to, xc, dc, own, oa, od, ow, bd, nx);
        model_finish(exp_own, 1'b0);
        total++; if (own !== exp_own) begin bad++; $display("[TB] FAIL sim_second_owner: got %b expected %b", own, exp_own); end
        total++; if (xc != 2) begin bad++; $display("[TB] FAIL sim_second_xfer: got %0d expected 2", xc); end
        total++; if (oa !== addr1) begin bad++; $display("[TB] FAIL sim_second_addr: got %h expected %h", oa, addr1); end
        total++; if (dc - xc != 3 || to) begin bad++; $display("[TB] FAIL sim_second_latency: got %0d expected 3", dc - xc); end
        step();
        last_rd = 32'h3333_4444;
    endtask

    task automatic test_wait_states();
        bit to, bd; int xc, dc, nx; logic own, ow, exp_own; logic [DW-1:0] oa, od, rd;
        rd = $urandom;
        req1 = 1; req0 = 0; addr1 = $urandom; wdata1 = $urandom; write1 = 1;
        exp_own = model_winner(req0, req1);
        serve_one(3, 1, rd, 2, to, xc, dc, own, oa, od, ow, bd, nx);
        model_finish(exp_own, 1'b0);
        total++; if (xc != 1) begin bad++; $display("[TB] FAIL wait_xfer: got %0d expected 1", xc); end
        total++; if (dc != 7) begin bad++; $display("[TB] FAIL wait_done_cycle: got %0d expected 7", dc); end
        total++; if (rdata_q !== rd) begin bad++; $display("[TB] FAIL wait_rdata_q: got %h expected %h", rdata_q, rd); end
        total++; if (od !== wdata1 || ow !== 1'b1) begin bad++; $display("[TB] FAIL wait_cmd: got %h/%b expected %h/1", od, ow, wdata1); end
        total++; if (nx != 1) begin bad++; $display("[TB] FAIL wait_xfer_len: got %0d expected 1", nx); end
        step();
        last_rd = rd;
    endtask

    task automatic test_lock();
        bit to, bd; int xc, dc, nx; logic own, ow, exp_own; logic [DW-1:0] oa, od;
        logic exp_seq [5];
`ifdef APB_ARB_LOCK_EN
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
        do_reset();
        req0 = 1; lock0 = 1; req1 = 1; lock1 = 0; addr0 = $urandom; addr1 = $urandom;
        for (int i = 0; i < 5; i++) begin
            exp_own = model_winner(req0, req1);
            serve_one(0, 0, 32'(i + 1), (i == 4) ? 2 : 0, to, xc, dc, own, oa, od, ow, bd, nx);
            model_finish(exp_own, exp_own ? lock1 : lock0);
            total++; if (own !== exp_seq[i]) begin bad++; $display("[TB] FAIL lock_seq_%0d: got %b expected %b", i, own, exp_seq[i]); end
            total++; if (own !== exp_own) begin bad++; $display("[TB] FAIL lock_model_%0d: got %b expected %b", i, own, exp_own); end
            total++; if (to || xc != ((i == 0) ? 1 : 2)) begin bad++; $display("[TB] FAIL lock_xfer_%0d: got %0d expected %0d", i, xc, (i == 0) ? 1 : 2); end
        end
        lock0 = 0;
        step();
        last_rd = 32'd5;
    endtask

    task automatic test_random();
        bit to, bd; int xc, dc, nx, waits; bit spur; logic own, ow, exp_own;
        logic [DW-1:0] oa, od, rd;
        for (int i = 0; i < 24; i++) begin
            logic [1:0] mask;
            mask = 2'($urandom_range(1, 3));
            req0 = mask[0]; req1 = mask[1];
            addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
            write0 = 1'($urandom_range(0, 1)); write1 = 1'($urandom_range(0, 1));
            lock0 = 1'($urandom_range(0, 1)); lock1 = 1'($urandom_range(0, 1));
            waits = $urandom_range(0, 3); spur = 1'($urandom_range(0, 1)); rd = $urandom;
            exp_own = model_winner(req0, req1);
            serve_one(waits, spur, rd, 2, to, xc, dc, own, oa, od, ow, bd, nx);
            total++; if (to || own !== exp_own) begin bad++; $display("[TB] FAIL rnd_owner_%0d: got %b expected %b", i, own, exp_own); end
            total++; if (xc != 1 || dc - xc != 3 + waits) begin bad++; $display("[TB] FAIL rnd_timing_%0d: got xfer=%0d done=%0d expected xfer=1 done=%0d", i, xc, dc, 4 + waits); end
            total++; if (oa !== (exp_own ? addr1 : addr0) || od !== (exp_own ? wdata1 : wdata0) || ow !== (exp_own ? write1 : write0)) begin
                bad++; $display("[TB] FAIL rnd_cmd_%0d: got %h/%h/%b expected %h/%h/%b", i, oa, od, ow,
                                exp_own ? addr1 : addr0, exp_own ? wdata1 : wdata0, exp_own ? write1 : write0);
            end
            total++; if (rdata_q !== rd) begin bad++; $display("[TB] FAIL rnd_rdata_q_%0d: got %h expected %h", i, rdata_q, rd); end
            total++; if (bd || nx != 1) begin bad++; $display("[TB] FAIL rnd_pulses_%0d: got bad_done=%b xfers=%0d expected 0 1", i, bd, nx); end
            model_finish(exp_own, exp_own ? lock1 : lock0);
            step();
            total++; if ({done0, done1, busy} !== 3'b000) begin bad++; $display("[TB] FAIL rnd_idle_%0d: got %b expected 000", i, {done0, done1, busy}); end
            last_rd = rd;
        end
        lock0 = 0; lock1 = 0;
    endtask

    task automatic test_reset_abort();
        bit to, bd; int xc, dc, nx, done_seen; logic own, ow; logic [DW-1:0] oa, od, rd;
        total++; if (rdata_q !== last_rd) begin bad++; $display("[TB] FAIL abort_pre_rdata_q: got %h expected %h", rdata_q, last_rd); end
        req0 = 1; req1 = 0; addr0 = $urandom; write0 = 0; ready = 0;
        step();
        total++; if (transfer !== 1'b1) begin bad++; $display("[TB] FAIL abort_issue: got %b expected 1", transfer); end
        step(); step(); step();
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL abort_busy_pre: got %b expected 1", busy); end
        #2 PRESET = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        total++; if (rdata_q !== '0) begin bad++; $display("[TB] FAIL abort_rdata_q: got %h expected 0", rdata_q); end
        total++; if ({transfer, done0, done1} !== 3'b000) begin bad++; $display("[TB] FAIL abort_outputs: got %b expected 000", {transfer, done0, done1}); end
        req0 = 0; done_seen = 0;
        repeat (3) begin
            step();
            if (done0 || done1) done_seen++;
        end
        #2 PRESET = 1'b1;
        model_reset();
        step();
        if (done0 || done1) done_seen++;
        total++; if (done_seen != 0) begin bad++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", done_seen); end
        rd = $urandom;
        req1 = 1; addr1 = $urandom; wdata1 = $urandom; write1 = 1;
        serve_one(1, 0, rd, 2, to, xc, dc, own, oa, od, ow, bd, nx);
        total++; if (to || own !== model_winner(1'b0, 1'b1)) begin bad++; $display("[TB] FAIL abort_after_owner: got %b expected 1", own); end
        total++; if (xc != 1 || dc != 5) begin bad++; $display("[TB] FAIL abort_after_timing: got %0d/%0d expected 1/5", xc, dc); end
        total++; if (rdata_q !== rd || bd) begin bad++; $display("[TB] FAIL abort_after_rdata_q: got %h expected %h", rdata_q, rd); end
        total++; if (oa !== addr1 || ow !== 1'b1) begin bad++; $display("[TB] FAIL abort_after_cmd: got %h/%b expected %h/1", oa, ow, addr1); end
        step();
    endtask

    initial begin
        $display("[TB] starting apb_arbiter bench");
        test_reset();
        test_single_read();
        test_simultaneous();
        test_wait_states();
        test_lock();
        test_random();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
